i2s_tx_ctrl: RTL and testbench

// - Sequencer and clock master for i2s_tx, in the same clock domain as i2s_tx (audio clock).
// - Derives sclk/lrclk from clk by integer division.
// - Serves i2s_tx frame requests from an upstream FWFT-less sample FIFO (1-cycle read latency).
// - Substitutes silence on underrun and handles clean start/stop on whole-frame boundaries.

---
 rtl/i2s_tx_ctrl_if.sv | 24 ++
 rtl/i2s_tx_ctrl.sv | 125 ++++++++++++
 tb/tb_i2s_tx_ctrl.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/i2s_tx_ctrl_if.sv
// FIFO-side and i2s_tx-side handshake bundle for i2s_tx_ctrl.
// master = the controller, slave = the FIFO / i2s_tx / bench side.
interface i2s_tx_ctrl_if #(
  parameter int DW = 24
);
  logic          fifo_empty;
  logic [DW-1:0] fifo_l;
  logic [DW-1:0] fifo_r;
  logic          fifo_rd_en;
  logic          tx_rd_en;
  logic [DW-1:0] tx_l;
  logic [DW-1:0] tx_r;
  logic          tx_valid;

  modport master (
    input  fifo_empty, fifo_l, fifo_r, tx_rd_en,
    output fifo_rd_en, tx_l, tx_r, tx_valid
  );

  modport slave (
    output fifo_empty, fifo_l, fifo_r, tx_rd_en,
    input  fifo_rd_en, tx_l, tx_r, tx_valid
  );
endinterface

// File: rtl/i2s_tx_ctrl.sv
// I2S transmit sequencer: divides clk into sclk/lrclk, feeds i2s_tx from a sample FIFO,
// substitutes silence on underrun. Optional saturating underrun counter: I2S_CTRL_UNDERRUN_CNT_EN.
module i2s_tx_ctrl #(
  parameter int DW          = 24,
  parameter int SCLK_HALF   = 4,
  parameter int BITS_PER_CH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  i2s_tx_ctrl_if.master        bus,
  output logic                 sclk,
  output logic                 lrclk,
  output logic                 running,
  output logic                 underrun
`ifdef I2S_CTRL_UNDERRUN_CNT_EN
  ,
  input  logic                 underrun_clr,
  output logic [15:0]          underrun_cnt
`endif
);

  localparam int DIV_W = $clog2(SCLK_HALF);
  localparam int BIT_W = $clog2(BITS_PER_CH);
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(SCLK_HALF - 1);
  localparam logic [BIT_W-1:0] BIT_MAX = BIT_W'(BITS_PER_CH - 1);

  typedef enum logic [1:0] {IDLE, RUN, STOP} state_t;

  state_t           state;
  logic [DIV_W-1:0] div_cnt;
  logic [BIT_W-1:0] bit_cnt;
  logic             req;
  logic             pend;
  logic             pend_data;
  logic             div_wrap;
  logic             sclk_fall;
  logic             frame_end;

  // A request is only honoured while clocks run; reset masks the combinational pop.
  assign req            = !rst && (state != IDLE) && bus.tx_rd_en;
  assign bus.fifo_rd_en = req && !bus.fifo_empty;
  assign div_wrap       = (div_cnt == DIV_MAX);
  assign sclk_fall      = div_wrap && sclk;
  assign frame_end      = sclk_fall && (bit_cnt == BIT_MAX) && lrclk;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      running      <= 1'b0;
      div_cnt      <= '0;
      bit_cnt      <= BIT_MAX;
      sclk         <= 1'b0;
      lrclk        <= 1'b1;
      pend         <= 1'b0;
      pend_data    <= 1'b0;
      underrun     <= 1'b0;
      bus.tx_valid <= 1'b0;
      bus.tx_l     <= '0;
      bus.tx_r     <= '0;
    end else begin
      // Two-stage request pipeline: FIFO data arrives one cycle after the pop.
      pend         <= req;
      pend_data    <= bus.fifo_rd_en;
      underrun     <= req && bus.fifo_empty;
      bus.tx_valid <= pend;
      if (pend) begin
        bus.tx_l <= pend_data ? bus.fifo_l : {DW{1'b0}};
        bus.tx_r <= pend_data ? bus.fifo_r : {DW{1'b0}};
      end

      case (state)
        IDLE: begin
          div_cnt <= '0;
          bit_cnt <= BIT_MAX;
          sclk    <= 1'b0;
          lrclk   <= 1'b1;
          if (enable && !bus.fifo_empty) begin
            state   <= RUN;
            running <= 1'b1;
          end
        end
        RUN, STOP: begin
          // Stopping only lands on the falling sclk edge that would begin a new frame.
          if (state == STOP && !enable && frame_end) begin
            state   <= IDLE;
            running <= 1'b0;
            div_cnt <= '0;
            bit_cnt <= BIT_MAX;
            sclk    <= 1'b0;
            lrclk   <= 1'b1;
          end else begin
            state <= enable ? RUN : STOP;
            if (div_wrap) begin
              div_cnt <= '0;
              sclk    <= !sclk;
              if (sclk) begin
                bit_cnt <= (bit_cnt == BIT_MAX) ? '0 : bit_cnt + 1'b1;
                if (bit_cnt == BIT_MAX) lrclk <= !lrclk;
              end
            end else begin
              div_cnt <= div_cnt + 1'b1;
            end
          end
        end
        default: begin
          state   <= IDLE;
          running <= 1'b0;
        end
      endcase
    end
  end

`ifdef I2S_CTRL_UNDERRUN_CNT_EN
  // Clear wins over a simultaneous increment.
  always_ff @(posedge clk) begin
    if (rst || underrun_clr) begin
      underrun_cnt <= 16'd0;
    end else if (req && bus.fifo_empty && underrun_cnt != 16'hFFFF) begin
      underrun_cnt <= underrun_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_i2s_tx_ctrl.sv
// Directed bench for i2s_tx_ctrl: FIFO model, request scoreboard and arithmetic clock model.
module tb_i2s_tx_ctrl;
  localparam int DW          = 24;
  localparam int SCLK_HALF   = 4;
  localparam int BITS_PER_CH = 32;
  localparam int CHAN_LEN    = 2 * SCLK_HALF * BITS_PER_CH;
  localparam int FRAME_LEN   = 2 * CHAN_LEN;
  localparam int LEAD        = 2 * SCLK_HALF;

  logic clk = 1'b0;
  logic rst;
  logic enable;
  logic sclk;
  logic lrclk;
  logic running;
  logic underrun;
`ifdef I2S_CTRL_UNDERRUN_CNT_EN
  logic        underrun_clr;
  logic [15:0] underrun_cnt;
  int          exp_cnt = 0;
`endif

  i2s_tx_ctrl_if #(.DW(DW)) bus ();

  i2s_tx_ctrl #(
    .DW(DW), .SCLK_HALF(SCLK_HALF), .BITS_PER_CH(BITS_PER_CH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .enable(enable),
    .bus(bus),
    .sclk(sclk),
    .lrclk(lrclk),
    .running(running),
    .underrun(underrun)
`ifdef I2S_CTRL_UNDERRUN_CNT_EN
    ,
    .underrun_clr(underrun_clr),
    .underrun_cnt(underrun_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int            due;
    logic          under;
    logic [DW-1:0] l;
    logic [DW-1:0] r;
  } exp_t;

  typedef struct {
    logic [DW-1:0] l;
    logic [DW-1:0] r;
  } smp_t;

  exp_t sb[$];
  smp_t fq[$];

  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   run_base = 0;
  int   start_at = -1;
  int   idle_at = -1;
  int   falls = 0;
  logic exp_running = 1'b0;
  logic exp_rd_en = 1'b0;
  logic force_empty = 1'b0;
  logic prev_lr = 1'b1;
  logic exp_valid = 1'b0;
  logic exp_under = 1'b0;
  logic exp_sclk = 1'b0;
  logic exp_lr = 1'b1;
  logic [DW-1:0] exp_l = '0;
  logic [DW-1:0] exp_r = '0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic update_empty();
    bus.fifo_empty = force_empty || (fq.size() == 0);
  endtask

  task automatic set_force(input logic v);
    force_empty = v;
    update_empty();
  endtask

  task automatic push_sample(input logic [DW-1:0] l, input logic [DW-1:0] r);
    smp_t s;
    s.l = l;
    s.r = r;
    fq.push_back(s);
    update_empty();
  endtask

  task automatic check_output();
    check_val("running", 32'(running), 32'(exp_running));
    check_val("sclk", 32'(sclk), 32'(exp_sclk));
    check_val("lrclk", 32'(lrclk), 32'(exp_lr));
    check_val("tx_valid", 32'(bus.tx_valid), 32'(exp_valid));
    check_val("tx_l", 32'(bus.tx_l), 32'(exp_l));
    check_val("tx_r", 32'(bus.tx_r), 32'(exp_r));
    check_val("underrun", 32'(underrun), 32'(exp_under));
`ifdef I2S_CTRL_UNDERRUN_CNT_EN
    check_val("underrun_cnt", 32'(underrun_cnt), 32'(exp_cnt));
`endif
  endtask

  task automatic tick();
    logic pop;
    logic rst_s;
    logic clr_s;
    int   ph;
    smp_t s;
    @(negedge clk);
    check_val("fifo_rd_en", 32'(bus.fifo_rd_en), 32'(exp_rd_en));
    pop   = bus.fifo_rd_en;
    rst_s = rst;
`ifdef I2S_CTRL_UNDERRUN_CNT_EN
    clr_s = underrun_clr;
`else
    clr_s = 1'b0;
`endif
    @(posedge clk);
    #1;
    cyc++;
    if (pop === 1'b1 && fq.size() > 0) begin
      s = fq.pop_front();
      bus.fifo_l = s.l;
      bus.fifo_r = s.r;
    end
    update_empty();
    if (prev_lr === 1'b1 && lrclk === 1'b0) falls++;
    prev_lr = lrclk;

    if (rst_s) begin
      sb.delete();
      exp_running = 1'b0;
      start_at = -1;
      idle_at = -1;
      exp_l = '0;
      exp_r = '0;
    end else begin
      if (cyc == start_at) begin
        exp_running = 1'b1;
        run_base = cyc;
      end
      if (cyc == idle_at) exp_running = 1'b0;
    end

    exp_valid = (sb.size() > 0) && (sb[0].due == cyc);
    exp_under = 1'b0;
    foreach (sb[i]) if (sb[i].under && sb[i].due == cyc + 1) exp_under = 1'b1;
    if (exp_valid) begin
      exp_l = sb[0].l;
      exp_r = sb[0].r;
    end
    if (exp_running) begin
      ph = cyc - run_base;
      exp_sclk = ((ph / SCLK_HALF) % 2) == 1;
      exp_lr = (ph < LEAD) ? 1'b1 : ((((ph - LEAD) / CHAN_LEN) % 2) == 1);
    end else begin
      exp_sclk = 1'b0;
      exp_lr = 1'b1;
    end
`ifdef I2S_CTRL_UNDERRUN_CNT_EN
    if (rst_s || clr_s) exp_cnt = 0;
    else if (exp_under && exp_cnt != 65535) exp_cnt++;
`else
    if (clr_s) exp_under = exp_under;
`endif
    check_output();
    if (exp_valid) void'(sb.pop_front());
  endtask

  // Drives one cycle of tx_rd_en and records what the request must produce.
  task automatic apply_stimulus(input logic req);
    exp_t e;
    bus.tx_rd_en = req;
    exp_rd_en = 1'b0;
    if (req && exp_running && !rst) begin
      e.due = cyc + 2;
      e.under = bus.fifo_empty;
      if (e.under) begin
        e.l = '0;
        e.r = '0;
      end else begin
        e.l = fq[0].l;
        e.r = fq[0].r;
      end
      exp_rd_en = !e.under;
      sb.push_back(e);
    end
    tick();
    bus.tx_rd_en = 1'b0;
  endtask

  initial begin
    int i;
    int t0;
    int k;
    rst = 1'b1;
    enable = 1'b0;
    bus.tx_rd_en = 1'b0;
    bus.fifo_l = '0;
    bus.fifo_r = '0;
`ifdef I2S_CTRL_UNDERRUN_CNT_EN
    underrun_clr = 1'b0;
`endif
    update_empty();
    apply_stimulus(1'b0);
    apply_stimulus(1'b0);
    rst = 1'b0;

    push_sample(24'hABCDEF, 24'h123456);
    for (int j = 0; j < 12; j++) push_sample(DW'($urandom), DW'($urandom));

    // Disabled: requests must be ignored and clocks parked.
    for (int j = 0; j < 100; j++) apply_stimulus((j % 10) == 5);

    enable = 1'b1;
    start_at = cyc + 1;
    falls = 0;
    apply_stimulus(1'b0);
    check_val("running_after_enable", 32'(running), 32'd1);

    i = 0;
    while (lrclk !== 1'b0 && i < 20) begin apply_stimulus(1'b0); i++; end
    check_val("lrclk_first_fall", 32'(cyc - run_base), 32'(LEAD));
    t0 = cyc;
    i = 0;
    while (lrclk !== 1'b1 && i < 400) begin apply_stimulus(1'b0); i++; end
    check_val("lrclk_half_period", 32'(cyc - t0), 32'(CHAN_LEN));
    i = 0;
    while (lrclk !== 1'b0 && i < 400) begin apply_stimulus(1'b0); i++; end
    check_val("lrclk_period", 32'(cyc - t0), 32'(FRAME_LEN));

    apply_stimulus(1'b1);
    repeat (4) apply_stimulus(1'b0);
    apply_stimulus(1'b1);
    apply_stimulus(1'b1);
    repeat (6) apply_stimulus(1'b0);

    set_force(1'b1);
    apply_stimulus(1'b1);
    repeat (3) apply_stimulus(1'b0);
    set_force(1'b0);
    apply_stimulus(1'b1);
    repeat (3) apply_stimulus(1'b0);
    // Empty asserting in the request cycle itself.
    set_force(1'b1);
    apply_stimulus(1'b1);
    set_force(1'b0);
    repeat (3) apply_stimulus(1'b0);

`ifdef I2S_CTRL_UNDERRUN_CNT_EN
    underrun_clr = 1'b1;
    apply_stimulus(1'b0);
    underrun_clr = 1'b0;
    set_force(1'b1);
    underrun_clr = 1'b1;
    apply_stimulus(1'b1);
    underrun_clr = 1'b0;
    repeat (3) apply_stimulus(1'b0);
    apply_stimulus(1'b1);
    repeat (3) apply_stimulus(1'b0);
    check_val("cnt_one", 32'(underrun_cnt), 32'd1);
    repeat (65536) apply_stimulus(1'b1);
    repeat (3) apply_stimulus(1'b0);
    check_val("cnt_saturated", 32'(underrun_cnt), 32'hFFFF);
    underrun_clr = 1'b1;
    apply_stimulus(1'b0);
    underrun_clr = 1'b0;
    set_force(1'b0);
`endif

    // Stop in the middle of a right channel.
    i = 0;
    while (lrclk !== 1'b0 && i < 600) begin apply_stimulus(1'b0); i++; end
    i = 0;
    while (lrclk !== 1'b1 && i < 600) begin apply_stimulus(1'b0); i++; end
    repeat (40) apply_stimulus(1'b0);
    enable = 1'b0;
    k = (cyc + 2 - run_base - LEAD + FRAME_LEN - 1) / FRAME_LEN;
    idle_at = run_base + LEAD + k * FRAME_LEN;
    i = 0;
    while (running === 1'b1 && i < FRAME_LEN + 100) begin apply_stimulus(1'b0); i++; end
    check_val("stop_idle_cycle", 32'(cyc), 32'(idle_at));
    check_val("frames_started", 32'(falls), 32'(k));
    for (int j = 0; j < 100; j++) apply_stimulus((j % 7) == 3);
    check_val("frames_after_idle", 32'(falls), 32'(k));

    // Reset one cycle after a pop drops the in-flight strobe.
    push_sample(24'h5A5A5A, 24'hA5A5A5);
    enable = 1'b1;
    start_at = cyc + 1;
    repeat (30) apply_stimulus(1'b0);
    apply_stimulus(1'b1);
    rst = 1'b1;
    enable = 1'b0;
    apply_stimulus(1'b0);
    check_val("rst_tx_valid", 32'(bus.tx_valid), 32'd0);
    check_val("rst_lrclk", 32'(lrclk), 32'd1);
    rst = 1'b0;
    repeat (5) apply_stimulus(1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
